// File: rtl/hdma_ctrl.sv
// ---------------------------------------------------------------------------
// hdma_ctrl -- CGB VRAM DMA engine (general-purpose and HBlank transfers).
//
// Moves 16-byte blocks from the system bus into VRAM at two ce-cycles per
// byte: a read cycle (src_rd) followed by a write cycle (vram_wren).
//
// Ports
//   clk_sys       in   system clock
//   reset         in   synchronous active-high reset
//   ce            in   clock enable; nothing advances while low
//   isGBC         in   1 = CGB mode, 0 = block disabled
//   cpu_sel_reg   in   CPU is accessing the FF00-FF7F register page
//   cpu_addr[7:0] in   register offset (0x51-0x55 decoded)
//   cpu_wr        in   CPU write strobe
//   cpu_di[7:0]   in   CPU write data
//   cpu_do[7:0]   out  read data (0xFF when not decoded)
//   lcd_mode[1:0] in   PPU mode (0 = HBlank, 3 = pixel transfer)
//   hdma_active   out  CPU stall request while bytes are moved
//   src_addr[15:0]out  source bus address
//   src_rd        out  source read strobe
//   src_data[7:0] in   source data, valid one ce-cycle after src_rd
//   vram_addr[12:0]out VRAM write address (offset from 0x8000)
//   vram_wren     out  VRAM write strobe
//   vram_wr_data  out  VRAM write data
// ---------------------------------------------------------------------------
module hdma_ctrl (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce,
  input  logic        isGBC,
  input  logic        cpu_sel_reg,
  input  logic [7:0]  cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_di,
  output logic [7:0]  cpu_do,
  input  logic [1:0]  lcd_mode,
  output logic        hdma_active,
  output logic [15:0] src_addr,
  output logic        src_rd,
  input  logic [7:0]  src_data,
  output logic [12:0] vram_addr,
  output logic        vram_wren,
  output logic [7:0]  vram_wr_data
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GDMA    = 2'd1,
    ST_HB_WAIT = 2'd2,
    ST_HB_XFER = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  len_q, len_d;
  logic [15:0] src_q, src_d;
  logic [12:0] dst_q, dst_d;
  // Position inside the current block: even = read cycle, odd = write cycle.
  logic [4:0]  phase_q, phase_d;
  logic [1:0]  lcd_prev_q, lcd_prev_d;
  logic        hdma_active_q, hdma_active_d;
  logic        src_rd_q, src_rd_d;
  logic [15:0] src_addr_q, src_addr_d;
  logic        vram_wren_q, vram_wren_d;
  logic [12:0] vram_addr_q, vram_addr_d;

  logic reg_wr_s;
  logic hb_edge_s;
  logic xfer_s;

  assign reg_wr_s  = cpu_sel_reg & cpu_wr & isGBC;
  assign hb_edge_s = (lcd_prev_q == 2'd3) && (lcd_mode == 2'd0);
  assign xfer_s    = (state_q == ST_GDMA) || (state_q == ST_HB_XFER);

  // Next-state, counter and strobe computation for one ce-qualified edge.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    src_d         = src_q;
    dst_d         = dst_q;
    phase_d       = phase_q;
    lcd_prev_d    = lcd_prev_q;
    hdma_active_d = hdma_active_q;
    src_rd_d      = src_rd_q;
    src_addr_d    = src_addr_q;
    vram_wren_d   = vram_wren_q;
    vram_addr_d   = vram_addr_q;

    if (ce) begin
      lcd_prev_d = lcd_mode;
      if (!isGBC) begin
        // Disabled block: park in IDLE with all strobes low.
        state_d       = ST_IDLE;
        hdma_active_d = 1'b0;
        src_rd_d      = 1'b0;
        vram_wren_d   = 1'b0;
      end else if (xfer_s) begin
        if (!phase_q[0]) begin
          // Read cycle ends: data arrives during the following write cycle.
          src_rd_d    = 1'b0;
          vram_wren_d = 1'b1;
          vram_addr_d = dst_q;
          phase_d     = phase_q + 5'd1;
        end else begin
          vram_wren_d = 1'b0;
          src_d       = src_q + 16'd1;
          dst_d       = dst_q + 13'd1;
          if (phase_q == 5'd31) begin
            phase_d = 5'd0;
            if (len_q == 7'd0) begin
              state_d       = ST_IDLE;
              len_d         = 7'h7F;
              hdma_active_d = 1'b0;
              src_rd_d      = 1'b0;
            end else begin
              len_d = len_q - 7'd1;
              if (state_q == ST_GDMA) begin
                // General DMA runs blocks back to back.
                src_rd_d   = 1'b1;
                src_addr_d = src_q + 16'd1;
              end else begin
                state_d       = ST_HB_WAIT;
                hdma_active_d = 1'b0;
                src_rd_d      = 1'b0;
              end
            end
          end else begin
            phase_d    = phase_q + 5'd1;
            src_rd_d   = 1'b1;
            src_addr_d = src_q + 16'd1;
          end
        end
      end else begin
        // Address registers load the live counters, only while not stalling.
        if (reg_wr_s && !hdma_active_q) begin
          case (cpu_addr)
            8'h51:   src_d = {cpu_di, src_q[7:0]};
            8'h52:   src_d = {src_q[15:8], cpu_di[7:4], 4'h0};
            8'h53:   dst_d = {cpu_di[4:0], dst_q[7:0]};
            8'h54:   dst_d = {dst_q[12:8], cpu_di[7:4], 4'h0};
            default: src_d = src_q;
          endcase
        end else begin
          src_d = src_q;
        end

        if (reg_wr_s && (cpu_addr == 8'h55)) begin
          if (state_q == ST_IDLE) begin
            len_d = cpu_di[6:0];
            if (cpu_di[7]) begin
              state_d = ST_HB_WAIT;
            end else begin
              state_d       = ST_GDMA;
              phase_d       = 5'd0;
              hdma_active_d = 1'b1;
              src_rd_d      = 1'b1;
              src_addr_d    = src_d;
            end
          end else if (cpu_di[7]) begin
            // HB_WAIT: restart HBlank mode with the new length.
            len_d = cpu_di[6:0];
          end else begin
            // HB_WAIT: cancel, remaining length is kept for readback.
            state_d = ST_IDLE;
          end
        end else if ((state_q == ST_HB_WAIT) && hb_edge_s) begin
          state_d       = ST_HB_XFER;
          phase_d       = 5'd0;
          hdma_active_d = 1'b1;
          src_rd_d      = 1'b1;
          src_addr_d    = src_d;
        end else begin
          state_d = state_q;
        end
      end
    end else begin
      state_d = state_q;
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      len_q         <= 7'h7F;
      src_q         <= 16'h0000;
      dst_q         <= 13'h0000;
      phase_q       <= 5'd0;
      lcd_prev_q    <= 2'd0;
      hdma_active_q <= 1'b0;
      src_rd_q      <= 1'b0;
      src_addr_q    <= 16'h0000;
      vram_wren_q   <= 1'b0;
      vram_addr_q   <= 13'h0000;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      src_q         <= src_d;
      dst_q         <= dst_d;
      phase_q       <= phase_d;
      lcd_prev_q    <= lcd_prev_d;
      hdma_active_q <= hdma_active_d;
      src_rd_q      <= src_rd_d;
      src_addr_q    <= src_addr_d;
      vram_wren_q   <= vram_wren_d;
      vram_addr_q   <= vram_addr_d;
    end
  end

  // Register readback: only FF55 returns live status.
  always_comb begin
    cpu_do = 8'hFF;
    if (isGBC && cpu_sel_reg && (cpu_addr == 8'h55)) begin
      cpu_do = {(state_q == ST_IDLE), len_q};
    end else begin
      cpu_do = 8'hFF;
    end
  end

  assign hdma_active = hdma_active_q;
  assign src_rd      = src_rd_q;
  assign src_addr    = src_addr_q;
  assign vram_wren   = vram_wren_q;
  assign vram_addr   = vram_addr_q;
  // Source data only becomes valid in the write cycle, so it is passed
  // through there and forced to zero otherwise.
  assign vram_wr_data = vram_wren_q ? src_data : 8'h00;

endmodule

// File: tb/tb_hdma_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hdma_ctrl -- self-checking bench for hdma_ctrl.
// The reference model is a byte list: a transfer of N bytes from S to D
// writes mem(S+i) to (D+i) mod 8K for i = 0..N-1, and the stall line is
// high for exactly 2 ce-cycles per byte moved.
// ---------------------------------------------------------------------------
module tb_hdma_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset, ce, isGBC, cpu_sel_reg, cpu_wr;
  logic [7:0]  cpu_addr, cpu_di, cpu_do;
  logic [1:0]  lcd_mode;
  logic        hdma_active, src_rd, vram_wren;
  logic [15:0] src_addr;
  logic [7:0]  src_data = 8'h00;
  logic [12:0] vram_addr;
  logic [7:0]  vram_wr_data;

  int n_cmp = 0;
  int n_bad = 0;
  int act_cnt = 0;
  int act_base, obs_base;
  logic [20:0] obs_q[$];
  logic [20:0] exp_q[$];
  logic [7:0]  seed;
  logic [7:0]  rv;
  logic [15:0] s_eff;
  logic [12:0] d_eff;

  hdma_ctrl dut (
    .clk_sys(clk_sys), .reset(reset), .ce(ce), .isGBC(isGBC),
    .cpu_sel_reg(cpu_sel_reg), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr),
    .cpu_di(cpu_di), .cpu_do(cpu_do), .lcd_mode(lcd_mode),
    .hdma_active(hdma_active), .src_addr(src_addr), .src_rd(src_rd),
    .src_data(src_data), .vram_addr(vram_addr), .vram_wren(vram_wren),
    .vram_wr_data(vram_wr_data)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return (a[7:0] * 8'd29) ^ a[15:8] ^ seed;
  endfunction

  // Synchronous source memory: data valid one ce-cycle after src_rd.
  always @(posedge clk_sys) begin
    if (ce && src_rd) src_data <= mem_f(src_addr);
  end

  // Monitor: one sample per consumed ce-cycle.
  always @(negedge clk_sys) begin
    if (ce && !reset) begin
      if (hdma_active) act_cnt <= act_cnt + 1;
      if (vram_wren) obs_q.push_back({vram_addr, vram_wr_data});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    cpu_sel_reg = 1'b1; cpu_wr = 1'b1; cpu_addr = a; cpu_di = d;
    tick(1);
    cpu_sel_reg = 1'b0; cpu_wr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    cpu_sel_reg = 1'b1; cpu_addr = a;
    #1;
    v = cpu_do;
    cpu_sel_reg = 1'b0;
  endtask

  // Program source/destination and return the effective addresses.
  task automatic setup(input logic [15:0] s, input logic [7:0] dh, input logic [7:0] dl);
    wr(8'h51, s[15:8]); wr(8'h52, s[7:0]); wr(8'h53, dh); wr(8'h54, dl);
    s_eff = {s[15:4], 4'h0};
    d_eff = {dh[4:0], dl[7:4], 4'h0};
  endtask

  task automatic mark();
    act_base = act_cnt;
    obs_base = obs_q.size();
    exp_q.delete();
  endtask

  task automatic expect_bytes(input logic [15:0] s, input logic [12:0] d, input int n);
    for (int i = 0; i < n; i++)
      exp_q.push_back({13'(d + 13'(i)), mem_f(16'(s + 16'(i)))});
  endtask

  task automatic check_xfer(input string tag, input int act_exp);
    chk($sformatf("%s active", tag), 32'(act_cnt - act_base), 32'(act_exp));
    chk($sformatf("%s nwrites", tag), 32'(obs_q.size() - obs_base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (obs_base + i < obs_q.size())
        chk($sformatf("%s wr%0d", tag, i), 32'(obs_q[obs_base + i]), 32'(exp_q[i]));
  endtask

  initial begin
    logic [6:0]  len;
    logic [15:0] rs;
    int ones;
    seed = 8'($urandom);
    reset = 1'b1; ce = 1'b1; isGBC = 1'b1; cpu_sel_reg = 1'b0; cpu_wr = 1'b0;
    cpu_addr = 8'h00; cpu_di = 8'h00; lcd_mode = 2'd0;

    // Reset state
    tick(3);
    chk("rst hdma_active", 32'(hdma_active), 32'd0);
    chk("rst src_rd", 32'(src_rd), 32'd0);
    chk("rst vram_wren", 32'(vram_wren), 32'd0);
    chk("rst src_addr", 32'(src_addr), 32'd0);
    chk("rst vram_addr", 32'(vram_addr), 32'd0);
    chk("rst vram_wr_data", 32'(vram_wr_data), 32'd0);
    reset = 1'b0;
    tick(1);
    rd(8'h55, rv); chk("rst ff55", 32'(rv), 32'hFF);
    rd(8'h51, rv); chk("rst ff51", 32'(rv), 32'hFF);

    // Directed GDMA C000 -> 8000, one block
    setup(16'hC000, 8'h80, 8'h00);
    mark(); expect_bytes(s_eff, d_eff, 16);
    wr(8'h55, 8'h00);
    tick(40);
    check_xfer("gdma", 32);
    rd(8'h55, rv); chk("gdma ff55", 32'(rv), 32'hFF);
    chk("gdma idle active", 32'(hdma_active), 32'd0);

    // Random GDMA; a source write while stalled must be ignored
    for (int k = 0; k < 3; k++) begin
      rs = 16'($urandom);
      setup(rs, 8'($urandom), 8'($urandom));
      len = 7'($urandom_range(0, 2));
      mark(); expect_bytes(s_eff, d_eff, 16 * (int'(len) + 1));
      wr(8'h55, {1'b0, len});
      wr(8'h51, 8'($urandom));
      tick((int'(len) + 1) * 32 + 6);
      check_xfer($sformatf("rgdma%0d", k), 32 * (int'(len) + 1));
      rd(8'h55, rv); chk($sformatf("rgdma%0d ff55", k), 32'(rv), 32'hFF);
    end

    // HBlank, two blocks
    setup(16'($urandom), 8'($urandom), 8'($urandom));
    lcd_mode = 2'd3; tick(2);
    mark();
    wr(8'h55, 8'h81);
    tick(20);
    check_xfer("hb wait", 0);
    mark(); expect_bytes(s_eff, d_eff, 16);
    lcd_mode = 2'd0; tick(40);
    check_xfer("hb blk1", 32);
    rd(8'h55, rv); chk("hb blk1 ff55", 32'(rv), 32'h00);
    lcd_mode = 2'd3; tick(3);
    mark(); expect_bytes(16'(s_eff + 16'd16), 13'(d_eff + 13'd16), 16);
    lcd_mode = 2'd0; tick(40);
    check_xfer("hb blk2", 32);
    rd(8'h55, rv); chk("hb blk2 ff55", 32'(rv), 32'hFF);

    // Cancel after one block
    setup(16'($urandom), 8'($urandom), 8'($urandom));
    lcd_mode = 2'd3; tick(2);
    wr(8'h55, 8'h85);
    mark(); expect_bytes(s_eff, d_eff, 16);
    lcd_mode = 2'd0; tick(40);
    check_xfer("cancel blk", 32);
    rd(8'h55, rv); chk("cancel ff55 a", 32'(rv), 32'h04);
    wr(8'h55, 8'h00);
    rd(8'h55, rv); chk("cancel ff55 b", 32'(rv), 32'h84);
    lcd_mode = 2'd3; tick(3);
    mark();
    lcd_mode = 2'd0; tick(40);
    check_xfer("cancel after", 0);

    // Source and destination wrap
    setup(16'hFFF5, 8'h9F, 8'hF0);
    mark(); expect_bytes(s_eff, d_eff, 32);
    wr(8'h55, 8'h01);
    tick(70);
    check_xfer("wrap", 64);

    // Reset during byte 5 of a GDMA
    setup(16'($urandom), 8'($urandom), 8'($urandom));
    mark(); expect_bytes(s_eff, d_eff, 5);
    wr(8'h55, 8'h00);
    tick(10);
    reset = 1'b1;
    tick(1);
    chk("rstmid active", 32'(hdma_active), 32'd0);
    chk("rstmid src_rd", 32'(src_rd), 32'd0);
    chk("rstmid wren", 32'(vram_wren), 32'd0);
    rd(8'h55, rv); chk("rstmid ff55", 32'(rv), 32'hFF);
    reset = 1'b0;
    tick(40);
    check_xfer("rstmid", 10);

    // isGBC=0: everything ignored, counters stay at their reset values
    isGBC = 1'b0;
    mark();
    wr(8'h51, 8'h12); wr(8'h53, 8'h05); wr(8'h55, 8'h00);
    tick(40);
    check_xfer("nogbc", 0);
    rd(8'h55, rv); chk("nogbc ff55", 32'(rv), 32'hFF);
    isGBC = 1'b1;
    rd(8'h55, rv); chk("nogbc idle ff55", 32'(rv), 32'hFF);
    mark(); expect_bytes(16'h0000, 13'h0000, 16);
    wr(8'h55, 8'h00);
    tick(40);
    check_xfer("nogbc after", 32);

    // ce held low in the write cycle of byte 3, then random ce
    setup(16'($urandom), 8'($urandom), 8'($urandom));
    mark(); expect_bytes(s_eff, d_eff, 16);
    wr(8'h55, 8'h00);
    tick(7);
    ce = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick(1);
      chk("ce0 wren", 32'(vram_wren), 32'd1);
      chk("ce0 vram_addr", 32'(vram_addr), 32'(13'(d_eff + 13'd3)));
      chk("ce0 data", 32'(vram_wr_data), 32'(mem_f(16'(s_eff + 16'd3))));
      chk("ce0 src_addr", 32'(src_addr), 32'(16'(s_eff + 16'd3)));
      chk("ce0 src_rd", 32'(src_rd), 32'd0);
      chk("ce0 active", 32'(hdma_active), 32'd1);
    end
    ones = 0;
    for (int t = 0; t < 400 && ones < 40; t++) begin
      ce = 1'($urandom_range(0, 1));
      if (ce) ones++;
      tick(1);
    end
    ce = 1'b1;
    tick(2);
    check_xfer("ce", 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
